// File: rtl/wb_ctrl.sv
// Writeback controller: merges ALU and load results into a circular queue
// and drains one entry per cycle into the register-file write port.
module wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    input  logic                     wb_stall,
    input  logic                     flush,
    output logic                     RegWrite,
    output logic [4:0]               rc,
    output logic [31:0]              dc,
    input  logic [4:0]               ra,
    input  logic [4:0]               rb,
    output logic                     hazard_a,
    output logic                     hazard_b,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t         q [DEPTH];
    wb_ent_t         in_ent;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            full, mem_fire, alu_fire, push, pop;
    logic [DEPTH-1:0] hit_a, hit_b;

    // Loads win arbitration; full uses the pre-edge count so a pop never reopens ready.
    assign full      = (count == CW'(DEPTH));
    assign mem_ready = !full && !flush;
    assign alu_ready = !full && !flush && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign in_ent    = mem_fire ? wb_ent_t'{mem_rd, mem_data} : wb_ent_t'{alu_rd, alu_data};
    assign push      = (mem_fire || alu_fire) && (in_ent.rd != 5'd0);
    assign pop       = !wb_stall && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            rc       <= '0;
            dc       <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (flush) begin
            RegWrite <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                rc     <= q[rd_ptr].rd;
                dc     <= q[rd_ptr].data;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; stale slots are masked by the occupancy window.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push)
            q[wr_ptr] <= in_ent;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] ofs;
        logic          vld;
        assign ofs      = PW'(i) - rd_ptr;
        assign vld      = ({1'b0, ofs} < count);
        assign hit_a[i] = vld && (q[i].rd == ra);
        assign hit_b[i] = vld && (q[i].rd == rb);
    end

    assign hazard_a = (ra != 5'd0) && ((|hit_a) || (RegWrite && rc == ra));
    assign hazard_b = (rb != 5'd0) && ((|hit_b) || (RegWrite && rc == rb));
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_ctrl;
    localparam int DEPTH = 4;

    logic        clk, rst_n;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rc, ra, rb;
    logic [31:0] alu_data, mem_data, dc;
    logic        wb_stall, flush, RegWrite, hazard_a, hazard_b;
    logic [$clog2(DEPTH):0] count;

    wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_stall(wb_stall), .flush(flush),
        .RegWrite(RegWrite), .rc(rc), .dc(dc),
        .ra(ra), .rb(rb), .hazard_a(hazard_a), .hazard_b(hazard_b), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the write-port registers.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_rc;
    logic [31:0] m_dc;

    always @(posedge clk) begin
        ent_t in_e, head;
        bit   acc, do_pop;
        if (!rst_n) begin
            mq.delete();
            m_rw = 0; m_rc = 0; m_dc = 0;
            chk_on = 1;
        end else if (flush) begin
            mq.delete();
            m_rw = 0;
        end else begin
            acc = 0;
            if (mq.size() < DEPTH) begin
                if (mem_valid) begin acc = 1; in_e.rd = mem_rd; in_e.data = mem_data; end
                else if (alu_valid) begin acc = 1; in_e.rd = alu_rd; in_e.data = alu_data; end
            end
            do_pop = !wb_stall && mq.size() > 0;
            m_rw = do_pop;
            if (do_pop) begin
                head = mq.pop_front();
                m_rc = head.rd; m_dc = head.data;
            end
            if (acc && in_e.rd != 0) mq.push_back(in_e);
        end
    end

    function automatic bit m_hz(input logic [4:0] r);
        if (r == 0) return 0;
        if (m_rw && m_rc == r) return 1;
        foreach (mq[i]) if (mq[i].rd == r) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("RegWrite", 32'(RegWrite), 32'(m_rw));
            chk("rc", 32'(rc), 32'(m_rc));
            chk("dc", dc, m_dc);
            chk("count", 32'(count), 32'(mq.size()));
            chk("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH && !flush));
            chk("alu_ready", 32'(alu_ready), 32'(mq.size() < DEPTH && !flush && !mem_valid));
            chk("hazard_a", 32'(hazard_a), 32'(m_hz(ra)));
            chk("hazard_b", 32'(hazard_b), 32'(m_hz(rb)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; wb_stall = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0; cyc(); cyc(); rst_n = 1;
    endtask

    initial begin
        rst_n = 0; idle();
        alu_rd = 0; alu_data = 0; mem_rd = 0; mem_data = 0; ra = 0; rb = 0;
        do_reset();
        #1;
        chk("rst RegWrite", 32'(RegWrite), 0);
        chk("rst count", 32'(count), 0);
        chk("rst mem_ready", 32'(mem_ready), 1);
        chk("rst alu_ready", 32'(alu_ready), 1);
        chk("rst hazard_a", 32'(hazard_a), 0);

        // Single write latency
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; cyc();
        alu_valid = 0;
        chk("single cnt", 32'(count), 1);
        chk("single no bypass", 32'(RegWrite), 0);
        cyc();
        chk("single rw", 32'(RegWrite), 1);
        chk("single rc", 32'(rc), 5);
        chk("single dc", dc, 32'hDEADBEEF);
        cyc();
        chk("single rw off", 32'(RegWrite), 0);

        // Load beats ALU
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h44; #1;
        chk("cont alu_ready", 32'(alu_ready), 0);
        chk("cont mem_ready", 32'(mem_ready), 1);
        cyc(); mem_valid = 0;
        cyc(); alu_valid = 0;
        chk("cont first rc", 32'(rc), 4);
        chk("cont first rw", 32'(RegWrite), 1);
        cyc();
        chk("cont second rc", 32'(rc), 3);
        chk("cont second dc", dc, 32'h33);
        cyc();

        // Fill under stall, then drain in order
        wb_stall = 1;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(i * 16); cyc();
        end
        alu_valid = 0; #1;
        chk("fill count", 32'(count), 4);
        chk("fill mem_ready", 32'(mem_ready), 0);
        chk("fill alu_ready", 32'(alu_ready), 0);
        wb_stall = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("drain rw", 32'(RegWrite), 1);
            chk("drain rc", 32'(rc), 32'(i));
        end
        cyc();
        chk("drain done", 32'(RegWrite), 0);

        // r0 writes are accepted but dropped
        mem_valid = 1; mem_rd = 0; mem_data = 32'h1; ra = 0; #1;
        chk("r0 ready", 32'(mem_ready), 1);
        cyc(); mem_valid = 0;
        chk("r0 count", 32'(count), 0);
        cyc();
        chk("r0 rw", 32'(RegWrite), 0);
        chk("r0 hazard", 32'(hazard_a), 0);

        // Hazard lifetime
        wb_stall = 1; alu_valid = 1; alu_rd = 7; alu_data = 32'h77; cyc();
        alu_valid = 0; ra = 7; #1;
        chk("hz queued", 32'(hazard_a), 1);
        wb_stall = 0; cyc();
        chk("hz issuing rw", 32'(RegWrite), 1);
        chk("hz issuing", 32'(hazard_a), 1);
        cyc();
        chk("hz cleared", 32'(hazard_a), 0);
        ra = 0;

        // Flush, then reset during drain
        wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_rd = 5'(9 + i); mem_data = 32'(i); cyc();
        end
        mem_valid = 0; flush = 1; cyc();
        flush = 0;
        chk("flush count", 32'(count), 0);
        chk("flush rw", 32'(RegWrite), 0);
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_rd = 5'(12 + i); mem_data = 32'h100 + 32'(i); cyc();
        end
        mem_valid = 0; wb_stall = 0; cyc();
        rst_n = 0; cyc(); rst_n = 1;
        chk("rst mid rw", 32'(RegWrite), 0);
        chk("rst mid rc", 32'(rc), 0);
        chk("rst mid dc", dc, 0);
        chk("rst mid count", 32'(count), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            wb_stall  = ($urandom_range(0, 99) < 40);
            alu_valid = $urandom_range(0, 1);
            mem_valid = ($urandom_range(0, 2) == 0);
            alu_rd    = 5'($urandom_range(0, 7));
            mem_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_data  = $urandom;
            ra        = 5'($urandom_range(0, 7));
            rb        = 5'($urandom_range(0, 7));
            cyc();
        end
        idle(); rst_n = 1;
        repeat (8) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, writeback queue entries (power of two, 2..16).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: alu_valid  in  1  ALU result offered.
REQ-005 Port: alu_ready  out  1  ALU result accepted this cycle if alu_valid.
REQ-006 Port: alu_rd  in  5  ALU destination register.
REQ-007 Port: alu_data  in  32  ALU result value.
REQ-008 Port: mem_valid  in  1  load result offered.
REQ-009 Port: mem_ready  out  1  load result accepted this cycle if mem_valid.
REQ-010 Port: mem_rd  in  5  load destination register.
REQ-011 Port: mem_data  in  32  load result value.
REQ-012 Port: wb_stall  in  1  register-file write port unavailable; hold queue.
REQ-013 Port: flush  in  1  discard all queued and issuing writes.
REQ-014 Port: RegWrite  out  1  register-file write enable (registered).
REQ-015 Port: rc  out  5  register-file write address (registered).
REQ-016 Port: dc  out  32  register-file write data (registered).
REQ-017 Port: ra, rb  in  5 each  register-file read addresses under decode.
REQ-018 Port: hazard_a, hazard_b  out  1 each  pending write exists to ra / rb.
REQ-019 Port: count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-020 Queue SHALL be a circular FIFO of DEPTH {rd,data} entries with wrapping read/write pointers.
REQ-021 full = (count==DEPTH); mem_ready SHALL = !full && !flush; alu_ready SHALL = !full && !flush && !mem_valid (load priority, one enqueue per cycle).
REQ-022 full is evaluated on pre-edge count; a same-cycle pop SHALL NOT reopen ready.
REQ-023 Accepted transfer with rd==0 SHALL complete handshake but SHALL NOT be enqueued (count unchanged).
REQ-024 Each edge with !flush && !wb_stall && count>0: head SHALL pop into RegWrite=1, rc=head.rd, dc=head.data.
REQ-025 Each edge with count==0, wb_stall, or flush: RegWrite SHALL be 0; rc/dc hold previous values.
REQ-026 Latency: enqueue at edge N into empty, unstalled queue -> RegWrite=1 after edge N+1; register file commits at edge N+2.
REQ-027 Enqueue into empty queue SHALL NOT bypass to outputs in the same edge.
REQ-028 Simultaneous enqueue and pop SHALL leave count unchanged; order preserved strictly FIFO.
REQ-029 wb_stall SHALL freeze pointers and entries; enqueue continues while !full.
REQ-030 flush SHALL at next edge set count=0, pointers=0, RegWrite=0; flush overrides enqueue and pop.
REQ-031 hazard_a (combinational) SHALL = (ra!=0) && (any valid queue entry rd==ra || (RegWrite && rc==ra)); hazard_b likewise for rb.
REQ-032 Incoming (not yet accepted) transfers SHALL NOT contribute to hazard outputs.

Reset
REQ-033 rst_n low at an edge SHALL set RegWrite=0, rc=0, dc=0, count=0, both pointers=0; queue contents don't-care.
REQ-034 Reset SHALL override flush, wb_stall and handshakes; transfers in the reset cycle are lost.
REQ-035 After reset, with empty queue, hazard_a=hazard_b=0 and both readies=1 (mem_valid=0).

Verification
REQ-036 Single write: alu_valid, rd=5, data=0xDEADBEEF at edge 1 -> RegWrite=1, rc=5, dc=0xDEADBEEF after edge 2, RegWrite=0 after edge 3.
REQ-037 Contention: alu rd=3 and mem rd=4 valid same cycle -> alu_ready=0; mem entry issued first, alu entry next cycle.
REQ-038 Fill: wb_stall=1, enqueue 4 entries rd=1..4 -> count=4, both readies=0; drop stall -> RegWrite 4 consecutive cycles, rc=1,2,3,4.
REQ-039 r0 drop: mem rd=0 data=0x1 accepted -> count stays 0, no RegWrite pulse, hazard_a=0 with ra=0.
REQ-040 Hazard: queue holds rd=7, ra=7 -> hazard_a=1; after write issued and following cycle, hazard_a=0.
REQ-041 Flush/reset: 3 entries queued, flush=1 -> count=0, RegWrite=0 next edge; rst_n=0 mid-drain -> all outputs zero next edge.
